// File: rtl/pad_ctrl_pkg.sv
// Shared types and constants for the pad configuration sequencer.
package pad_ctrl_pkg;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned PAD_CFG_W = 6;
    localparam int unsigned PAD_IDX_W = 5;
    localparam int unsigned MAX_PADS  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISOLATE,
        APPLY,
        HOLD
    } pad_state_e;

endpackage

// File: rtl/pad_ctrl_rr_arb.sv
// Two-way round-robin arbiter: ptr names the favoured requester, grant is one-hot.
module pad_ctrl_rr_arb
    import pad_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid[ptr]) begin
            grant[ptr] = 1'b1;
        end else if (valid[~ptr]) begin
            grant[~ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Pad reconfiguration sequencer: isolates a pad, settles, applies cfg/mux, holds, then releases.
module pad_cfg_sequencer
    import pad_ctrl_pkg::*;
#(
    parameter int NUM_PADS      = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0][PAD_IDX_W-1:0]  req_pad_i,
    input  logic [NUM_REQ-1:0][PAD_CFG_W-1:0]  req_cfg_i,
    input  logic [NUM_REQ-1:0]                 req_mux_i,
    output logic [MAX_PADS-1:0][PAD_CFG_W-1:0] pad_cfg_o,
    output logic [MAX_PADS-1:0]                pad_mux_o,
    output logic [MAX_PADS-1:0]                pad_oen_force_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               done_id_o,
    output logic                               err_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = SETTLE_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [PAD_IDX_W:0] PAD_LIMIT   = NUM_PADS[PAD_IDX_W:0];

    pad_state_e                          state;
    logic [CNT_W-1:0]                    cnt;
    logic                                rr_ptr;
    logic [NUM_REQ-1:0]                  grant;
    logic                                win_id;
    logic                                pad_ok;
    logic [PAD_IDX_W-1:0]                cur_pad;
    logic [PAD_CFG_W-1:0]                cur_cfg;
    logic                                cur_mux;
    logic                                cur_id;
    logic [NUM_PADS-1:0][PAD_CFG_W-1:0]  cfg_q;
    logic [NUM_PADS-1:0]                 mux_q;
    logic [NUM_PADS-1:0]                 force_q;
    logic                                done_q;
    logic                                done_id_q;
    logic                                err_q;

    pad_ctrl_rr_arb u_arb (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Grant is only exposed while idle and out of reset, so ready doubles as the handshake.
    assign req_ready_o = grant & {NUM_REQ{(state == IDLE) && !rst}};
    assign win_id      = grant[1];
    assign pad_ok      = {1'b0, req_pad_i[win_id]} < PAD_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= 1'b0;
            cur_pad   <= '0;
            cur_cfg   <= '0;
            cur_mux   <= 1'b0;
            cur_id    <= 1'b0;
            cfg_q     <= '0;
            mux_q     <= '0;
            force_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_ready_o) begin
                        rr_ptr <= grant[0];
                        if (pad_ok) begin
                            cur_pad <= req_pad_i[win_id];
                            cur_cfg <= req_cfg_i[win_id];
                            cur_mux <= req_mux_i[win_id];
                            cur_id  <= win_id;
                            for (int unsigned i = 0; i < NUM_PADS; i++) begin
                                force_q[i] <= (req_pad_i[win_id] == PAD_IDX_W'(i));
                            end
                            cnt   <= SETTLE_LOAD;
                            state <= ISOLATE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISOLATE: begin
                    if (cnt == CNT_ONE) begin
                        state <= APPLY;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                APPLY: begin
                    for (int unsigned i = 0; i < NUM_PADS; i++) begin
                        if (cur_pad == PAD_IDX_W'(i)) begin
                            cfg_q[i] <= cur_cfg;
                            mux_q[i] <= cur_mux;
                        end
                    end
                    cnt   <= SETTLE_LOAD;
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt == CNT_ONE) begin
                        state     <= IDLE;
                        force_q   <= '0;
                        done_q    <= 1'b1;
                        done_id_q <= cur_id;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_PADS; g++) begin : g_pad
        if (g < NUM_PADS) begin : g_live
            assign pad_cfg_o[g]       = cfg_q[g];
            assign pad_mux_o[g]       = mux_q[g];
            assign pad_oen_force_o[g] = force_q[g];
        end else begin : g_tied
            assign pad_cfg_o[g]       = '0;
            assign pad_mux_o[g]       = 1'b0;
            assign pad_oen_force_o[g] = 1'b0;
        end
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Randomised scoreboard bench for pad_cfg_sequencer with a timeline-based reference model.
module tb_pad_cfg_sequencer;

    localparam int TB_PADS   = 21;
    localparam int TB_SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][4:0]  req_pad;
    logic [1:0][5:0]  req_cfg;
    logic [1:0]       req_mux;
    logic [31:0][5:0] pad_cfg;
    logic [31:0]      pad_mux;
    logic [31:0]      pad_force;
    logic             busy, done, done_id, err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit is_err;
        bit id;
        int due;
    } ev_t;
    ev_t evq[$];

    // reference model state: one in-flight op described by its handshake cycle
    bit               m_active = 1'b0;
    int               m_t      = 0;
    int               m_pad    = 0;
    logic [5:0]       m_cfgv   = '0;
    bit               m_muxv   = 1'b0;
    bit               m_id     = 1'b0;
    bit               m_ptr    = 1'b0;
    logic [31:0][5:0] m_cfg    = '0;
    logic [31:0]      m_mux    = '0;
    logic [1:0]       exp_rdy;
    logic [31:0]      exp_force;
    int               w;
    ev_t              ev;

    logic [1:0]       acc;
    logic [1:0]       hold_prev = '0;
    logic [1:0][4:0]  pad_prev;
    logic [1:0][5:0]  cfg_prev;
    logic [1:0]       mux_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pad_cfg_sequencer #(
        .NUM_PADS      (TB_PADS),
        .SETTLE_CYCLES (TB_SETTLE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_pad_i       (req_pad),
        .req_cfg_i       (req_cfg),
        .req_mux_i       (req_mux),
        .pad_cfg_o       (pad_cfg),
        .pad_mux_o       (pad_mux),
        .pad_oen_force_o (pad_force),
        .busy_o          (busy),
        .done_o          (done),
        .done_id_o       (done_id),
        .err_o           (err)
    );

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_event(input bit is_err, input bit id);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d got=1 want=0", is_err ? "err" : "done", cyc);
        end else begin
            e = evq.pop_front();
            if (e.is_err != is_err || e.due != cyc || (!is_err && e.id != id)) begin
                failures++;
                $display("FAIL event cyc=%0d got=(err=%0d id=%0d) want=(err=%0d id=%0d due=%0d)",
                         cyc, is_err, id, e.is_err, e.id, e.due);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a completion or error pulse.
    always @(negedge clk) begin
        while (evq.size() > 0 && evq[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_event cyc=%0d got=none want=(err=%0d id=%0d due=%0d)",
                     cyc, evq[0].is_err, evq[0].id, evq[0].due);
            void'(evq.pop_front());
        end
        if (done) expect_event(1'b0, done_id);
        if (err)  expect_event(1'b1, 1'b0);
    end

    // Model: checks the level outputs for this cycle, then advances across the coming edge.
    always @(negedge clk) begin
        #1;
        exp_rdy = 2'b00;
        if (!rst && !m_active) begin
            if (req_valid[m_ptr])       exp_rdy[m_ptr]  = 1'b1;
            else if (req_valid[!m_ptr]) exp_rdy[!m_ptr] = 1'b1;
        end
        exp_force = m_active ? (32'd1 << m_pad) : 32'd0;
        check("ready", 192'(req_ready), 192'(exp_rdy));
        check("busy",  192'(busy),      192'(m_active));
        check("force", 192'(pad_force), 192'(exp_force));
        check("cfg",   192'(pad_cfg),   192'(m_cfg));
        check("mux",   192'(pad_mux),   192'(m_mux));

        if (rst) begin
            m_active = 1'b0;
            m_ptr    = 1'b0;
            m_cfg    = '0;
            m_mux    = '0;
            evq.delete();
        end else begin
            if (m_active && cyc == m_t + TB_SETTLE + 1) begin
                m_cfg[m_pad] = m_cfgv;
                m_mux[m_pad] = m_muxv;
            end
            if (m_active && cyc == m_t + 2 * TB_SETTLE + 1) m_active = 1'b0;
            if (exp_rdy != 2'b00) begin
                w     = exp_rdy[1] ? 1 : 0;
                m_ptr = (w == 0);
                ev.id = (w == 1);
                if (int'(req_pad[w]) >= TB_PADS) begin
                    ev.is_err = 1'b1;
                    ev.due    = cyc + 1;
                end else begin
                    m_active  = 1'b1;
                    m_t       = cyc;
                    m_pad     = int'(req_pad[w]);
                    m_cfgv    = req_cfg[w];
                    m_muxv    = req_mux[w];
                    m_id      = (w == 1);
                    ev.is_err = 1'b0;
                    ev.due    = cyc + 2 * TB_SETTLE + 2;
                end
                evq.push_back(ev);
            end
        end
    end

    // Requesters must hold payload stable while valid and not yet accepted.
    always @(negedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (hold_prev[r] && !rst) begin
                assert (req_valid[r] && req_pad[r] == pad_prev[r] &&
                        req_cfg[r] == cfg_prev[r] && req_mux[r] == mux_prev[r])
                else $error("requester %0d payload changed while waiting", r);
            end
            hold_prev[r] = !rst && req_valid[r] && !req_ready[r];
            pad_prev[r]  = req_pad[r];
            cfg_prev[r]  = req_cfg[r];
            mux_prev[r]  = req_mux[r];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [4:0] pad, input logic [5:0] cfg, input logic mux);
        bit got;
        got          = 1'b0;
        req_valid[r] = 1'b1;
        req_pad[r]   = pad;
        req_cfg[r]   = cfg;
        req_mux[r]   = mux;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = req_ready[r];
            if (!got) tick();
        end
        tick();
        req_valid[r] = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL handshake_timeout req=%0d got=0 want=1", r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_pad   = '0;
        req_cfg   = '0;
        req_mux   = '0;
        repeat (3) tick();
        rst = 1'b0;

        issue(0, 5'd5, 6'h2A, 1'b1);
        repeat (12) tick();

        rst = 1'b1;
        tick();
        rst        = 1'b0;
        req_pad[0] = 5'd3;
        req_cfg[0] = 6'h11;
        req_mux[0] = 1'b0;
        req_pad[1] = 5'd7;
        req_cfg[1] = 6'h22;
        req_mux[1] = 1'b1;
        req_valid  = 2'b11;
        repeat (25) tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;

        issue(1, 5'd25, 6'h3F, 1'b1);
        issue(1, 5'd4, 6'h15, 1'b0);
        repeat (12) tick();

        issue(0, 5'd9, 6'h07, 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] || acc[r]) begin
                    req_valid[r] = ($urandom_range(0, 2) == 0);
                    req_pad[r]   = 5'($urandom_range(0, 31));
                    req_cfg[r]   = 6'($urandom_range(0, 63));
                    req_mux[r]   = 1'($urandom_range(0, 1));
                end
            end
            rst = ($urandom_range(0, 399) == 0);
        end

        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        repeat (5) tick();

        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d want=0", evq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pad_cfg_sequencer.md
PAD_CFG_SEQUENCER -- requirements
Module: pad_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_PADS, default 32, meaning number of controlled pads (1..32).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, meaning isolation settle time in clk cycles (>=1).
REQ-003 SHALL have port clk  in  1  system clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  in  [1:0]  request valid; requester 0 is the SoC APB side, requester 1 is the JTAG side.
REQ-006 SHALL have port req_ready_o  out  [1:0]  request accepted this cycle.
REQ-007 SHALL have port req_pad_i  in  [1:0][4:0]  target pad index per requester.
REQ-008 SHALL have port req_cfg_i  in  [1:0][5:0]  new pad config per requester.
REQ-009 SHALL have port req_mux_i  in  [1:0]  new pad mux select per requester.
REQ-010 SHALL have port pad_cfg_o  out  [31:0][5:0]  per-pad config; entries >= NUM_PADS are tied to 0.
REQ-011 SHALL have port pad_mux_o  out  [31:0]  per-pad mux select.
REQ-012 SHALL have port pad_oen_force_o  out  [31:0]  1 forces the pad output-disable (isolation).
REQ-013 SHALL have port busy_o  out  1  sequence in progress.
REQ-014 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-015 SHALL have port done_id_o  out  1  requester index of the completed op; valid only while done_o=1.
REQ-016 SHALL have port err_o  out  1  one-cycle pulse when a request targets pad >= NUM_PADS.

Function
REQ-017 SHALL implement the FSM states IDLE, ISOLATE, APPLY and HOLD.
REQ-018 SHALL drive req_ready_o only in IDLE, to exactly one requester: the round-robin winner among valid requesters; at most one bit is high.
REQ-019 SHALL flip the round-robin pointer to favour the other requester after each accepted request; the reset pointer favours requester 0.
REQ-020 SHALL capture pad, cfg, mux and requester id on handshake (cycle T, IDLE) and move to ISOLATE.
REQ-021 SHALL remain in ISOLATE for cycles T+1..T+SETTLE_CYCLES, then APPLY for one cycle (T+S+1), writing cfg/mux so that they are visible from T+S+2.
REQ-022 SHALL remain in HOLD for cycles T+S+2..T+2S+1, then return to IDLE at T+2S+2 with done_o=1 and done_id_o set for that cycle.
REQ-023 SHALL assert pad_oen_force_o only on the captured pad, and only in ISOLATE, APPLY and HOLD; all other bits are 0.
REQ-024 SHALL accept a new request in the same cycle done_o is high; back-to-back ops therefore have 2S+2 cycles of spacing.
REQ-025 SHALL, for pad >= NUM_PADS, complete the handshake, stay in IDLE, pulse err_o at T+1, and change no outputs and no force bit.
REQ-026 SHALL run the full sequence even when the new cfg/mux equals the current value.
REQ-027 SHALL drive busy_o=1 iff state != IDLE.
REQ-028 SHALL size the settle counter to $clog2(SETTLE_CYCLES+1) bits with no wrap; it reloads on each state entry.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set state=IDLE, pad_cfg_o=0, pad_mux_o=0, pad_oen_force_o=0, busy_o=0, done_o=0, err_o=0, done_id_o=0, RR pointer=0; req_ready_o SHALL be 0 while rst=1.
REQ-030 SHALL, on a reset mid-sequence, drop the in-flight request, release force, and produce no done_o.

Structure
REQ-031 SHALL place the state enum, NUM_REQ=2 and PAD_CFG_W=6 in a shared package pad_ctrl_pkg.
REQ-032 SHALL implement round-robin grant in a sub-module pad_ctrl_rr_arb (inputs: valid vector and pointer; output: one-hot grant).

Verification
REQ-033 SHALL cover: reset; req0 pad 5 cfg 6'h2A mux 1 accepted at cycle 0 -> force[5]=1 at cycles 1..9, pad_cfg_o[5]=6'h2A and pad_mux_o[5]=1 from cycle 6, done_o=1 with done_id_o=0 at cycle 10.
REQ-034 SHALL cover: both valid from cycle 0 after reset -> req0 ready at 0, req1 ready at 10 despite req0 still valid, req0 ready at 20.
REQ-035 SHALL cover: NUM_PADS=21, req1 pad 25 -> handshake at 0, err_o=1 at 1, no force bit, outputs unchanged, ready available at 1.
REQ-036 SHALL cover: rst=1 during APPLY (cycle 5) -> cycle 6 shows all pad_cfg_o/pad_mux_o=0, force=0, busy_o=0, and no done_o follows.
REQ-037 SHALL cover: req1 valid held during busy -> req_ready_o[1]=0 until IDLE, with an assertion that payload is stable while valid and not ready.
